// File: rtl/sel_sequencer.sv
// sel_sequencer: steps the 2-bit decoder select code through 00..11 with a
// programmable dwell per code. It supports start/stop, manual single-step in
// IDLE, and one-shot (single pass) operation.
// Optional build macro SEL_SEQ_PINGPONG_EN: in RUN, bounce between 00 and 11
// using an internal direction bit instead of the dir input.
// Control pulses (start/stop/step) are single-cycle and sampled on the rising
// edge. All outputs are registers.
module sel_sequencer #(
   parameter int DW_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            stop,
   input  logic            step,
   input  logic            dir,
   input  logic            oneshot,
   input  logic [DW_W-1:0] dwell,
   output logic [1:0]      sel,
   output logic            busy,
   output logic            wrap,
   output logic            done
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      sel_q, sel_d;
   logic            busy_q, busy_d;
   logic            wrap_q, wrap_d;
   logic            done_q, done_d;
   logic [DW_W-1:0] cnt_q, cnt_d;
   logic [DW_W-1:0] dwell_q, dwell_d;
   logic            oneshot_q, oneshot_d;

   // Result of one RUN-mode advance from the current code.
   logic [1:0]      adv_sel;
   logic            adv_wrap;
   logic            adv_done;

`ifdef SEL_SEQ_PINGPONG_EN
   // Internal bounce direction: 1 = counting up.
   logic            pp_up_q, pp_up_d;
   logic            adv_up;
   logic            adv_up_next;

   // Compute the ping-pong advance; turn around at the terminal codes.
   always_comb begin
      adv_up = pp_up_q;
      if (pp_up_q && (sel_q == 2'b11)) begin
         adv_up = 1'b0;
      end else if (!pp_up_q && (sel_q == 2'b00)) begin
         adv_up = 1'b1;
      end
      adv_sel     = adv_up ? (sel_q + 2'd1) : (sel_q - 2'd1);
      adv_wrap    = adv_up ? (adv_sel == 2'b11) : (adv_sel == 2'b00);
      adv_up_next = adv_wrap ? ~adv_up : adv_up;
      adv_done    = oneshot_q && !adv_up && (adv_sel == 2'b00);
   end
`else
   // Compute the modulo-4 advance in the direction given by dir.
   always_comb begin
      adv_sel  = dir ? (sel_q - 2'd1) : (sel_q + 2'd1);
      adv_wrap = dir ? (sel_q == 2'b00) : (sel_q == 2'b11);
      adv_done = oneshot_q && adv_wrap;
   end
`endif

   // Next-state and output logic for the IDLE/RUN controller.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      dwell_d   = dwell_q;
      oneshot_d = oneshot_q;
      wrap_d    = 1'b0;
      done_d    = 1'b0;
`ifdef SEL_SEQ_PINGPONG_EN
      pp_up_d   = pp_up_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (stop) begin
               // stop beats start and step; nothing changes.
               state_d = ST_IDLE;
            end else if (start) begin
               state_d   = ST_RUN;
               dwell_d   = dwell;
               oneshot_d = oneshot;
               cnt_d     = '0;
`ifdef SEL_SEQ_PINGPONG_EN
               pp_up_d   = 1'b1;
`endif
            end else if (step) begin
               sel_d  = dir ? (sel_q - 2'd1) : (sel_q + 2'd1);
               wrap_d = dir ? (sel_q == 2'b00) : (sel_q == 2'b11);
            end
         end
         ST_RUN: begin
            if (stop) begin
               // stop pre-empts an advance due on the same edge.
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == dwell_q) begin
               cnt_d  = '0;
               sel_d  = adv_sel;
               wrap_d = adv_wrap;
               done_d = adv_done;
`ifdef SEL_SEQ_PINGPONG_EN
               pp_up_d = adv_up_next;
`endif
               if (adv_done) begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + DW_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == ST_RUN);
   end

   // State and output registers; reset aborts any run at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         sel_q     <= 2'b00;
         busy_q    <= 1'b0;
         wrap_q    <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
         dwell_q   <= '0;
         oneshot_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         wrap_q    <= wrap_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
         dwell_q   <= dwell_d;
         oneshot_q <= oneshot_d;
      end
   end

`ifdef SEL_SEQ_PINGPONG_EN
   // Ping-pong direction register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pp_up_q <= 1'b1;
      end else begin
         pp_up_q <= pp_up_d;
      end
   end
`endif

   assign sel  = sel_q;
   assign busy = busy_q;
   assign wrap = wrap_q;
   assign done = done_q;

endmodule

// File: tb/tb_sel_sequencer.sv
// tb_sel_sequencer: directed test of sel_sequencer with hand-computed
// expectations. Inputs are driven and outputs are sampled 1 time unit after
// each rising edge.
`timescale 1ns/1ps
module tb_sel_sequencer;

   localparam int DW_W = 8;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic            stop;
   logic            step;
   logic            dir;
   logic            oneshot;
   logic [DW_W-1:0] dwell;
   logic [1:0]      sel;
   logic            busy;
   logic            wrap;
   logic            done;

   int n_chk;
   int n_fail;

   sel_sequencer #(.DW_W(DW_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .stop    (stop),
      .step    (step),
      .dir     (dir),
      .oneshot (oneshot),
      .dwell   (dwell),
      .sel     (sel),
      .busy    (busy),
      .wrap    (wrap),
      .done    (done)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [1:0] e_sel, input logic e_busy,
                            input logic e_wrap, input logic e_done);
      check_val({tag, ".sel"},  {6'd0, sel},  {6'd0, e_sel});
      check_val({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
      check_val({tag, ".wrap"}, {7'd0, wrap}, {7'd0, e_wrap});
      check_val({tag, ".done"}, {7'd0, done}, {7'd0, e_done});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_step(input logic d);
      dir  = d;
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   logic [1:0] pp_sel  [6];
   logic       pp_wrap [6];

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      step    = 1'b0;
      dir     = 1'b0;
      oneshot = 1'b0;
      dwell   = '0;

      // Reset state.
      do_reset();
      check_out("reset", 2'b00, 1'b0, 1'b0, 1'b0);

`ifdef SEL_SEQ_PINGPONG_EN
      // Ping-pong one-shot pass: 01,10,11,10,01,00.
      pp_sel[0] = 2'b01; pp_wrap[0] = 1'b0;
      pp_sel[1] = 2'b10; pp_wrap[1] = 1'b0;
      pp_sel[2] = 2'b11; pp_wrap[2] = 1'b1;
      pp_sel[3] = 2'b10; pp_wrap[3] = 1'b0;
      pp_sel[4] = 2'b01; pp_wrap[4] = 1'b0;
      pp_sel[5] = 2'b00; pp_wrap[5] = 1'b1;
      dwell   = 8'd0;
      oneshot = 1'b1;
      dir     = 1'b1;
      pulse_start();
      check_out("pp_start", 2'b00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check_out("pp_seq", pp_sel[i], (i != 5), pp_wrap[i], (i == 5));
      end
      tick();
      check_out("pp_after", 2'b00, 1'b0, 1'b0, 1'b0);
`else
      // Continuous up-count, dwell=3: advance every 4 cycles.
      dwell   = 8'd3;
      dir     = 1'b0;
      oneshot = 1'b0;
      pulse_start();
      check_out("run_start", 2'b00, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         for (int h = 0; h < 3; h++) begin
            tick();
            check_out("run_hold", 2'(k - 1), 1'b1, 1'b0, 1'b0);
         end
         tick();
         check_out("run_adv", 2'(k % 4), 1'b1, (k == 4), 1'b0);
      end
      // Dwell change mid-run must not alter the period.
      tick();
      check_out("run_wrap_end", 2'b00, 1'b1, 1'b0, 1'b0);
      dwell = 8'd0;
      tick();
      check_out("dwell_chg_h1", 2'b00, 1'b1, 1'b0, 1'b0);
      tick();
      check_out("dwell_chg_h2", 2'b00, 1'b1, 1'b0, 1'b0);
      tick();
      check_out("dwell_chg_adv", 2'b01, 1'b1, 1'b0, 1'b0);
      // stop on the advance cycle: no advance, go IDLE.
      repeat (3) tick();
      check_out("pre_stop", 2'b01, 1'b1, 1'b0, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_out("stop_on_adv", 2'b01, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-run (dwell=0 latched now).
      pulse_start();
      check_out("run2_start", 2'b01, 1'b1, 1'b0, 1'b0);
      tick();
      check_out("run2_adv", 2'b10, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      check_out("async_rst", 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      check_out("post_rst", 2'b00, 1'b0, 1'b0, 1'b0);

      // One-shot down from 00 with dwell=0.
      dwell   = 8'd0;
      dir     = 1'b1;
      oneshot = 1'b1;
      pulse_start();
      check_out("os_start", 2'b00, 1'b1, 1'b0, 1'b0);
      tick();
      check_out("os_done", 2'b11, 1'b0, 1'b1, 1'b1);
      tick();
      check_out("os_hold1", 2'b11, 1'b0, 1'b0, 1'b0);
      tick();
      check_out("os_hold2", 2'b11, 1'b0, 1'b0, 1'b0);

      // Run dwell=5 up from 11, stop 2 cycles after reaching 10.
      dwell   = 8'd5;
      dir     = 1'b0;
      oneshot = 1'b0;
      pulse_start();
      for (int a = 0; a < 3; a++) begin
         repeat (5) tick();
         check_out("d5_hold", 2'(3 + a), 1'b1, 1'b0, 1'b0);
         tick();
         check_out("d5_adv", 2'(a), 1'b1, (a == 0), 1'b0);
      end
      // step in RUN is ignored.
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      check_out("step_in_run", 2'b10, 1'b1, 1'b0, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_out("stop_hold", 2'b10, 1'b0, 1'b0, 1'b0);
      tick();
      check_out("stop_idle", 2'b10, 1'b0, 1'b0, 1'b0);

      // Manual steps in IDLE.
      pulse_step(1'b0);
      check_out("step1", 2'b11, 1'b0, 1'b0, 1'b0);
      pulse_step(1'b0);
      check_out("step2_wrap", 2'b00, 1'b0, 1'b1, 1'b0);
      tick();
      check_out("step2_after", 2'b00, 1'b0, 1'b0, 1'b0);
      pulse_step(1'b1);
      check_out("step_dn_wrap", 2'b11, 1'b0, 1'b1, 1'b0);

      // start+stop together in IDLE: stay IDLE.
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check_out("start_stop", 2'b11, 1'b0, 1'b0, 1'b0);
      tick();
      check_out("start_stop2", 2'b11, 1'b0, 1'b0, 1'b0);

      // start+step together in IDLE: start wins, sel unchanged.
      dwell = 8'd1;
      dir   = 1'b0;
      start = 1'b1;
      step  = 1'b1;
      tick();
      start = 1'b0;
      step  = 1'b0;
      check_out("start_step", 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      check_out("ss_hold", 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      check_out("ss_adv", 2'b00, 1'b1, 1'b1, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sel_sequencer.md
Name: sel_sequencer

Overview:
- Sequential source for the 2-bit `sel` code that drives the downstream 4-bit pattern decoder.
- Steps `sel` through 00→01→10→11 (or the reverse) with a programmable dwell time per code.
- Supports start/stop control, manual single-step, and one-shot (single pass) operation.
- Has start/stop control, `busy`/`wrap`/`done` status, and no datapath beyond `sel`.

Parameters:
- DW_W, 8, width of the dwell count input and the internal dwell counter.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low; assertion resets immediately, release is synchronous to clk.
- start  in  1  single-cycle pulse; IDLE→RUN.
- stop  in  1  single-cycle pulse; RUN→IDLE.
- step  in  1  single-cycle pulse; advances `sel` one position while in IDLE.
- dir  in  1  0 = count up, 1 = count down; sampled at each advance.
- oneshot  in  1  sampled with `start`; 1 = stop after one pass.
- dwell  in  DW_W  cycles per code minus 1; sampled with `start`.
- sel  out  2  code to the downstream decoder; registered.
- busy  out  1  high while in RUN.
- wrap  out  1  one-cycle pulse when `sel` wraps (11→00 up, 00→11 down).
- done  out  1  one-cycle pulse when a one-shot pass completes.

Behaviour:
- Reset values:
  - sel=2'b00, busy=0, wrap=0, done=0.
  - Dwell counter=0, dwell_q=0, oneshot_q=0, state=IDLE.
  - Reset mid-RUN aborts immediately; no done pulse.
- FSM has two states, IDLE and RUN; `busy` = (state==RUN), registered.
- IDLE:
  - `sel` holds its value.
  - `start` → RUN on the next edge: latch dwell_q=dwell, oneshot_q=oneshot, clear the counter.
  - `step` advances `sel` by one in direction `dir` on the next edge; it pulses `wrap` if it crosses the boundary and never pulses `done`.
  - `step` and `start` in the same cycle: `start` wins, `step` is ignored.
- RUN:
  - The counter increments each cycle.
  - When counter==dwell_q: `sel` advances one position per `dir`, the counter clears to 0.
  - Resulting period is dwell_q+1 cycles per code; the first advance occurs dwell_q+1 cycles after `busy` rises.
  - dwell_q=0 gives an advance every cycle.
  - `dwell` changes during RUN are ignored until the next `start`.
- Arithmetic:
  - `sel` arithmetic is modulo 4.
  - `wrap` asserts on the same edge that `sel` takes the wrapped value, for exactly one cycle.
- One-shot:
  - If oneshot_q=1 and an advance wraps, the FSM → IDLE on that edge and `done` pulses together with `wrap`.
  - `sel` is left at the wrapped value (00 for up, 11 for down).
- stop / start / step in RUN:
  - `stop` in RUN → IDLE on the next edge; `sel` holds its current value; counter clears; no `done`.
  - `stop` has priority over an advance due in the same cycle, so no advance occurs.
  - `start` in RUN is ignored.
  - `step` in RUN is ignored.
- Simultaneous `start` and `stop` in IDLE: `stop` wins, remain IDLE.
- `dir` may change during RUN; the new value applies at the next advance.
- Outputs are glitch-free registers; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SEL_SEQ_PINGPONG_EN.
- Defined:
  - In RUN, `dir` is ignored. An internal direction bit is set to up at `start`.
  - It reverses at terminal codes, giving 00,01,10,11,10,01,00,01,…
  - `wrap` pulses on the advance that reaches a terminal code (11 or 00).
  - With oneshot_q=1, the pass ends on returning to 00; `done` and `wrap` pulse together and the FSM → IDLE.
  - IDLE `step` behaviour is unchanged and still uses `dir`.
- Undefined: modulo-4 wrap behaviour as in Behaviour; no internal direction register exists.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → sel=00, busy=wrap=done=0; assert rst_n low mid-RUN → all outputs return to reset values asynchronously.
- Continuous run: dwell=3, dir=0, oneshot=0, pulse start → busy=1 next cycle; sel 00→01→10→11→00 every 4 cycles; wrap=1 for one cycle coincident with 11→00.
- One-shot down: dwell=0, dir=1, oneshot=1, start with sel=00:
  - sel=11 after 1 cycle with wrap=1, done=1 and busy=0 on that edge.
  - sel holds 11 afterwards.
- Stop and step:
  - Run with dwell=5, pulse stop 2 cycles after sel reaches 10 → sel holds 10, busy=0, no done.
  - Then step ×2 with dir=0 → sel=11, then 00 with wrap pulse.
- Priority: start+stop same cycle in IDLE → remains IDLE. In RUN with stop on the advance cycle → no advance. Changing dwell mid-run → period unchanged.
- SEL_SEQ_PINGPONG_EN: dwell=0, oneshot=1, start → sel 01,10,11,10,01,00; wrap pulses at 11 and at 00; done with the final 00; busy low afterward.
